// File: rtl/mont_dispatch.sv
// mont_dispatch
//   Sequences one Montgomery multiplication between the 512-bit operand RAM
//   and a single multiplier core. Three consecutive RAM snapshots become the
//   operands A, B and M, the core is started, and its result is written back
//   through the RAM parallel port, waiting for the RAM's acknowledge.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   ram_doutb        RAM parallel read data
//   ram_doutb_valid  one-cycle pulse: RAM snapshot is complete
//   ram_dinb         result presented to the RAM
//   ram_web          one-cycle RAM parallel write enable
//   ram_dinb_read    RAM acknowledge of the write (cycle after ram_web or later)
//   core_a/b/m       operand registers feeding the core
//   core_start       one-cycle start pulse to the core
//   core_result      core output, valid with core_done
//   core_done        one-cycle pulse from the core
//   busy             low only while waiting for operand A
//   overrun          sticky: a snapshot arrived while no operand was expected
//   ops_done         completed-operation count (wraps)
module mont_dispatch #(
  parameter int DATA_W = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ram_doutb,
  input  logic              ram_doutb_valid,
  output logic [DATA_W-1:0] ram_dinb,
  output logic              ram_web,
  input  logic              ram_dinb_read,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  output logic [DATA_W-1:0] core_m,
  output logic              core_start,
  input  logic [DATA_W-1:0] core_result,
  input  logic              core_done,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_M,
    S_START,
    S_RUN,
    S_WRITE,
    S_ACK
  } state_e;

  state_e             state_q,    state_d;
  logic [DATA_W-1:0]  core_a_q,   core_a_d;
  logic [DATA_W-1:0]  core_b_q,   core_b_d;
  logic [DATA_W-1:0]  core_m_q,   core_m_d;
  logic [DATA_W-1:0]  ram_dinb_q, ram_dinb_d;
  logic               overrun_q,  overrun_d;
  logic [CNT_W-1:0]   ops_done_q, ops_done_d;

  logic load_state;

  assign load_state = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                      (state_q == S_LOAD_M);

  always_comb begin
    // NOTE: every signal assigned here first takes its hold value, so no path
    // leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    core_a_d   = core_a_q;
    core_b_d   = core_b_q;
    core_m_d   = core_m_q;
    ram_dinb_d = ram_dinb_q;
    overrun_d  = overrun_q;
    ops_done_d = ops_done_q;

    unique case (state_q)
      S_LOAD_A: if (ram_doutb_valid) begin
        core_a_d = ram_doutb;
        state_d  = S_LOAD_B;
      end
      S_LOAD_B: if (ram_doutb_valid) begin
        core_b_d = ram_doutb;
        state_d  = S_LOAD_M;
      end
      S_LOAD_M: if (ram_doutb_valid) begin
        core_m_d = ram_doutb;
        state_d  = S_START;
      end
      S_START: state_d = S_RUN;
      S_RUN: if (core_done) begin
        ram_dinb_d = core_result;
        state_d    = S_WRITE;
      end
      S_WRITE: state_d = S_ACK;
      S_ACK: if (ram_dinb_read) begin
        ops_done_d = ops_done_q + CNT_W'(1);
        state_d    = S_LOAD_A;
      end
      default: state_d = S_LOAD_A;
    endcase

    // A snapshot outside the load states is dropped; remember that it happened.
    if (ram_doutb_valid && !load_state) begin
      overrun_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LOAD_A;
      core_a_q   <= '0;
      core_b_q   <= '0;
      core_m_q   <= '0;
      ram_dinb_q <= '0;
      overrun_q  <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      core_a_q   <= core_a_d;
      core_b_q   <= core_b_d;
      core_m_q   <= core_m_d;
      ram_dinb_q <= ram_dinb_d;
      overrun_q  <= overrun_d;
      ops_done_q <= ops_done_d;
    end
  end

  // Strobes are decoded from state so each is exactly one cycle wide.
  assign core_start = (state_q == S_START);
  assign ram_web    = (state_q == S_WRITE);
  assign busy       = (state_q != S_LOAD_A);

  assign core_a   = core_a_q;
  assign core_b   = core_b_q;
  assign core_m   = core_m_q;
  assign ram_dinb = ram_dinb_q;
  assign overrun  = overrun_q;
  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_mont_dispatch.sv
// Self-checking bench for mont_dispatch. Expected write-back data is pushed
// to a scoreboard when the core result is driven and popped whenever the DUT
// asserts ram_web. The counter is narrowed to 4 bits so the wrap is reachable
// in a handful of operations.
module tb_mont_dispatch;

  localparam int DATA_W = 512;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] ram_doutb;
  logic              ram_doutb_valid;
  logic [DATA_W-1:0] ram_dinb;
  logic              ram_web;
  logic              ram_dinb_read;
  logic [DATA_W-1:0] core_a, core_b, core_m;
  logic              core_start;
  logic [DATA_W-1:0] core_result;
  logic              core_done;
  logic              busy;
  logic              overrun;
  logic [CNT_W-1:0]  ops_done;

  mont_dispatch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .ram_doutb       (ram_doutb),
    .ram_doutb_valid (ram_doutb_valid),
    .ram_dinb        (ram_dinb),
    .ram_web         (ram_web),
    .ram_dinb_read   (ram_dinb_read),
    .core_a          (core_a),
    .core_b          (core_b),
    .core_m          (core_m),
    .core_start      (core_start),
    .core_result     (core_result),
    .core_done       (core_done),
    .busy            (busy),
    .overrun         (overrun),
    .ops_done        (ops_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ops  = 0;
  logic [DATA_W-1:0] sb[$];

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    exp_ops = 0;
  endtask

  // Every write-back strobe must match the oldest outstanding result.
  always @(negedge clk) begin
    if (!reset && ram_web) begin
      if (sb.size() == 0) check("web_unexpected", 1, 0);
      else                check("wb_data", ram_dinb, sb.pop_front());
    end
  end

  // One full operation with back-to-back operand loads.
  task automatic run_op(input logic [DATA_W-1:0] a, b, m, res,
                        input bit inject_run, input int ack_delay,
                        input bit valid_at_ack);
    ram_doutb_valid = 1'b1; ram_doutb = a; tick();
    ram_doutb = b; tick();
    ram_doutb = m; tick();
    ram_doutb_valid = 1'b0; ram_doutb = '0;
    @(negedge clk);
    check("op_start", core_start, 1);
    tick();
    if (inject_run) begin
      ram_doutb_valid = 1'b1; ram_doutb = {64{8'h55}};
      tick();
      ram_doutb_valid = 1'b0;
      @(negedge clk);
      check("overrun_run", overrun, 1);
    end
    sb.push_back(res);
    core_done = 1'b1; core_result = res;
    tick();
    core_done = 1'b0;
    @(negedge clk);
    check("op_web", ram_web, 1);
    tick();
    for (int i = 0; i < ack_delay; i++) begin
      core_done   = (i == 0);
      core_result = ~res;
      @(negedge clk);
      check($sformatf("ack_wait_web%0d", i), ram_web, 0);
      check($sformatf("ack_wait_busy%0d", i), busy, 1);
      check($sformatf("ack_wait_dinb%0d", i), ram_dinb, res);
      tick();
      core_done = 1'b0;
    end
    ram_dinb_read = 1'b1;
    if (valid_at_ack) begin
      ram_doutb_valid = 1'b1; ram_doutb = {64{8'h77}};
    end
    tick();
    ram_dinb_read = 1'b0; ram_doutb_valid = 1'b0;
    exp_ops++;
    @(negedge clk);
    check("op_idle", busy, 0);
    check("op_ops", ops_done, DATA_W'(exp_ops % (1 << CNT_W)));
    check("op_a", core_a, a);
    check("op_b", core_b, b);
    check("op_m", core_m, m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] res_main;
    res_main        = {16'hDEAD, {60{8'hA5}}, 16'hBEEF};
    reset           = 1'b1;
    ram_doutb       = '0;
    ram_doutb_valid = 1'b0;
    ram_dinb_read   = 1'b0;
    core_result     = '0;
    core_done       = 1'b0;
    repeat (3) tick();

    // Reset state.
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start", core_start, 0);
    check("rst_web", ram_web, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ops", ops_done, 0);
    check("rst_a", core_a, 0);
    check("rst_dinb", ram_dinb, 0);
    tick();
    reset = 1'b0;

    // Reset in the middle of RUN abandons the operation.
    ram_doutb_valid = 1'b1; ram_doutb = DATA_W'(1); tick();
    ram_doutb = DATA_W'(2); tick();
    ram_doutb = DATA_W'(3); tick();
    ram_doutb_valid = 1'b0;
    @(negedge clk);
    check("mid_start", core_start, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_a", core_a, 0);
    check("mid_b", core_b, 0);
    check("mid_m", core_m, 0);
    check("mid_web", ram_web, 0);
    tick();
    core_done = 1'b1; core_result = {64{8'hEE}};
    tick();
    core_done = 1'b0;
    @(negedge clk);
    check("mid_done_ignored", busy, 0);
    tick();
    @(negedge clk);
    check("mid_no_web", ram_web, 0);
    check("mid_ops", ops_done, 0);
    tick();

    // Operand timing: valids on cycles 0, 5, 9; start on cycle 10 only.
    for (int c = 0; c <= 30; c++) begin
      ram_doutb_valid = (c == 0 || c == 5 || c == 9);
      ram_doutb = (c == 0) ? {64{8'h11}} : (c == 5) ? {64{8'h22}} :
                  (c == 9) ? {64{8'h33}} : {64{8'hC3}};
      if (c == 30) begin
        sb.push_back(res_main);
        core_done = 1'b1; core_result = res_main;
      end
      @(negedge clk);
      if (c >= 8 && c <= 12) check($sformatf("start_c%0d", c), core_start, c == 10);
      tick();
    end
    core_done = 1'b0; ram_doutb_valid = 1'b0;
    check("main_a", core_a, {64{8'h11}});
    check("main_b", core_b, {64{8'h22}});
    check("main_m", core_m, {64{8'h33}});
    @(negedge clk);
    check("main_web", ram_web, 1);
    tick();
    ram_dinb_read = 1'b1;
    @(negedge clk);
    check("main_web_once", ram_web, 0);
    tick();
    ram_dinb_read = 1'b0;
    exp_ops = 1;
    @(negedge clk);
    check("main_ops", ops_done, 1);
    check("main_busy", busy, 0);
    check("main_overrun", overrun, 0);
    tick();

    // Snapshot during RUN: dropped, overrun sticks past completion.
    run_op({64{8'h01}}, {64{8'h02}}, {64{8'h03}}, {64{8'h9A}}, 1'b1, 0, 1'b0);
    check("overrun_sticky", overrun, 1);

    // Delayed ack with a stray core_done and a valid coincident with the ack.
    do_reset();
    run_op({64{8'h0A}}, {64{8'h0B}}, {64{8'h0C}}, {64{8'h3C}}, 1'b0, 7, 1'b1);
    check("ack_valid_overrun", overrun, 1);

    // Counter wrap.
    do_reset();
    for (int k = 0; k < (1 << CNT_W); k++) begin
      run_op(DATA_W'(k + 100), DATA_W'(k + 200), DATA_W'(k + 300),
             {16'(k), 480'(0), 16'(~k)}, 1'b0, k % 3, 1'b0);
    end
    check("wrap_ops", ops_done, 0);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mont_dispatch.md
Name: mont_dispatch

Overview:
- Sits between the 512-bit operand RAM (32-bit AXI write port, 512-bit parallel port) and one Montgomery multiplier core.
- Collects three consecutive 512-bit RAM snapshots as operands A, B, M, then starts the core.
- Writes the core's 512-bit result back into the RAM through its parallel write port and waits for the RAM's acknowledge.

Parameters:
- DATA_W, 512, operand/result width; must equal the RAM parallel port width.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ram_doutb  in  DATA_W  RAM parallel read data
- ram_doutb_valid  in  1  one-cycle pulse: RAM fully written by host
- ram_dinb  out  DATA_W  result to RAM
- ram_web  out  1  RAM parallel write enable
- ram_dinb_read  in  1  RAM ack, registered; arrives the cycle after ram_web
- core_a, core_b, core_m  out  DATA_W  operand registers to core
- core_start  out  1  one-cycle start pulse
- core_result  in  DATA_W  core output
- core_done  in  1  one-cycle pulse: core_result valid
- busy  out  1  high in any state except LOAD_A
- overrun  out  1  sticky: ram_doutb_valid arrived while not in a LOAD state
- ops_done  out  CNT_W  completed-operation count

Behaviour:
- Reset (synchronous): state=LOAD_A; all outputs 0, including core_a/b/m and ram_dinb. Reset overrides everything, including a mid-operation state; no write-back occurs.
- States: LOAD_A -> LOAD_B -> LOAD_M -> START -> RUN -> WRITE -> ACK -> LOAD_A.
- LOAD_A / LOAD_B / LOAD_M:
  - On ram_doutb_valid, register ram_doutb into core_a / core_b / core_m respectively and advance.
  - Without valid, hold the state.
- START: core_start=1 for exactly one cycle; go to RUN.
  - Minimum latency is 1 cycle from the ram_doutb_valid that loads M to core_start high.
- RUN:
  - Wait for core_done; on it, register core_result into ram_dinb and go to WRITE.
  - core_done in any other state is ignored.
- WRITE: ram_web=1 for exactly one cycle; go to ACK.
- ACK:
  - Wait for ram_dinb_read.
  - On it: ops_done increments (wraps 2^CNT_W-1 -> 0); go to LOAD_A.
  - ram_dinb holds its value until the next result is latched.
- ram_doutb_valid while in START, RUN, WRITE or ACK:
  - data is discarded; overrun set to 1.
  - overrun clears only on reset.
- core_a/b/m hold stable from their load until the next load of the same register; the core may sample them at any time in RUN.
- ram_doutb_valid and ram_dinb_read in the same cycle while in ACK:
  - ack processed, state returns to LOAD_A;
  - the valid is counted as overrun, not loaded.
- busy is combinational from state (0 only in LOAD_A).
- Single outstanding operation; no queueing.

Test Plan:
- Reset mid-RUN (after A=1, B=2, M=3 loaded, core_start seen) -> next cycle: state LOAD_A, busy=0, core_a/b/m=0, ram_web=0, later core_done ignored, ops_done=0.
- Valids with data 0x11.., 0x22.., 0x33.. on cycles 0, 5, 9:
  - core_a=0x11.., core_b=0x22.., core_m=0x33..;
  - core_start high exactly on cycle 10, one cycle wide.
- core_done with result 0xDEAD..BEEF 20 cycles after start:
  - ram_dinb=0xDEAD..BEEF and ram_web=1 on the next cycle only;
  - ram_dinb_read one cycle later -> ops_done=1, busy=0.
- Valid pulse during RUN with data 0x55.. -> overrun=1, core_a/b/m unchanged, operation completes normally, overrun stays 1 after completion.
- ops_done preset path: run 65536 operations (or force counter to 0xFFFF) -> completion wraps ops_done to 0x0000.
- Delayed ack: ram_dinb_read withheld 7 cycles after ram_web -> state stays ACK, ram_web low throughout, ram_dinb stable; a core_done in that window is ignored.
